hdmi_pattern_gen: RTL
=====================

Name: hdmi_pattern_gen

Overview:
Synthetic HDMI source that drives hdmi_to_blocks directly from its upstream side. It produces raster timing (v_sync, h_sync, data_valid) with N pixels per clock, plus signed level-shifted YCbCr test patterns. It replaces the real HDMI receiver during bring-up and long-run regression, so full frames can reach the JPEG pipeline without an external video source.

Parameters:
N, 2, pixels per clock (lanes)
X_RES, 2160, active pixels per line; must be divisible by 8*N
Y_RES, 1200, active lines per frame; must be divisible by 8
H_SYNC_CYC, 20, h_sync width in clocks
H_BACK_PORCH_CYC, 46, clocks from h_sync fall to first valid
H_FRONT_PORCH_CYC, 40, clocks after last valid
V_SYNC_LINES, 2, lines with v_sync high
V_BACK_PORCH_LINES, 234, blank lines after v_sync
V_FRONT_PORCH_LINES, 28, blank lines after active region

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  clock enable; low freezes all state and outputs
pat_mode  in  2  0=RAMP, 1=BARS, 2=CHECKER, 3=FLAT; sampled at frame start
hdmi_v_sync  out  1  vertical sync
hdmi_h_sync  out  1  horizontal sync
hdmi_data_valid  out  1  active pixel cycle
hdmi_data_y  out  N x 8 signed  luma lanes; lane i is pixel col*N+i
hdmi_data_cb  out  N x 8 signed  Cb lanes
hdmi_data_cr  out  N x 8 signed  Cr lanes

Behaviour:
- Line period LP = H_SYNC_CYC + H_BACK_PORCH_CYC + X_RES/N + H_FRONT_PORCH_CYC clocks. Defaults give 1186.
- Frame period = (V_SYNC_LINES + V_BACK_PORCH_LINES + Y_RES + V_FRONT_PORCH_LINES) lines. Defaults give 1464 lines.
- Horizontal FSM: H_SYNC -> H_BP -> H_ACT -> H_FP -> H_SYNC. Each state lasts its parameter count. H_ACT lasts X_RES/N cycles.
- Vertical FSM advances on the last H_FP cycle of each line: V_SYNC -> V_BP -> V_ACT -> V_FP -> V_SYNC. Each state lasts its line count. V_ACT lasts Y_RES lines.
- Output rules:
  - h_sync = 1 in H_SYNC.
  - v_sync = 1 for every cycle of every V_SYNC line.
  - data_valid = 1 only in H_ACT during V_ACT.
- All outputs are registered. An output on edge t reflects FSM and counter state at t-1.
- Counters: col (0..X_RES/N-1) and row (0..Y_RES-1) count active-region positions only. Pixel x = col*N + i.
- Data while data_valid = 0: y/cb/cr = 0.
- Pattern equations; all arithmetic is mod 256 and reinterpreted as signed:
  - RAMP: y = x[7:0]+OFF; cb = row[7:0]; cr = x+row+OFF. OFF = 0 unless the optional feature is enabled.
  - BARS: k = x / (X_RES/8). y = 127-32k; cb = 32k-128; cr = k[0] ? 100 : -100.
  - CHECKER: y = (x[3]^row[3]) ? -100 : 100; cb = cr = 0.
  - FLAT: y = cb = cr = 0.
- pat_mode is latched on the first cycle of V_SYNC line 0. Changes mid-frame are ignored until the next frame.
- Reset:
  - All outputs 0. FSMs go to H_SYNC / V_SYNC line 0 with all counters 0. pat_mode is latched from the input during reset.
  - First edge with en = 1 after reset: h_sync = v_sync = 1.
  - Reset mid-line or mid-frame is an immediate restart, with no partial-line completion.
- en = 0: counters, FSMs and output registers hold their values. Pixel count per line is unaffected.

Optional Feature:
HDMI_PATGEN_FRAME_CNT_EN
- Defined:
  - Adds output frame_cnt (16 bits, unsigned). It resets to 0, increments on the transition V_FP -> V_SYNC, and wraps 65535 -> 0.
  - RAMP uses OFF = frame_cnt[7:0], so the pattern scrolls one step per frame.
- Undefined: the port is absent and OFF = 0.

Decomposition:
- Package hdmi_pkg holds:
  - pat_mode_t enum (RAMP, BARS, CHECKER, FLAT)
  - h_state_t / v_state_t enums
  - default timing constants
  - BAR_Y / BAR_CB / BAR_CR 8-entry signed constant tables
  - the CHECKER amplitude constant (100)
- Sub-module hdmi_timing_gen holds the FSMs, counters, sync/valid outputs, col/row and a frame_start strobe.
- The top level adds the pattern-mode latch and per-lane data generation.

Test Plan:
1. Default params, RAMP, en = 1 from reset. Required:
   - h_sync high 20 clocks, low 1166.
   - data_valid rises 66 clocks after h_sync rise and stays high 1080 clocks.
   - Line period is 1186.
2. Defaults. Required:
   - v_sync high for exactly 2372 clocks from the first edge after reset.
   - First data_valid occurs in line 236.
   - Next v_sync rise occurs 1736304 clocks after the first.
3. X_RES=16, Y_RES=8, N=2, RAMP. Required:
   - row 0, col 0: y = {0,1}, cb = {0,0}, cr = {0,1}.
   - row 3, col 2: y = {4,5}, cb = {3,3}, cr = {7,8}.
4. X_RES=32, Y_RES=16, CHECKER. Required:
   - row 0, x = 0..7: y = 100; x = 8: y = -100.
   - row 8, x = 0: y = -100.
   - cb = cr = 0 throughout.
5. en low 5 clocks mid-H_ACT, plus pat_mode RAMP -> BARS mid-frame. Required:
   - Outputs hold during en low; still 1080 valid cycles in that line.
   - Mode switches only after the next frame's v_sync rise.
6. Reset asserted mid-active line, then released. Required:
   - Valid and data are 0 during reset.
   - The first edge after release gives h_sync = v_sync = 1, col = row = 0.
   - With HDMI_PATGEN_FRAME_CNT_EN, frame_cnt = 0, and frame 1 RAMP y at x = 0 equals 1.

Source files
------------

// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared types and constants for the synthetic HDMI pattern source.
// The optional frame counter is enabled with the HDMI_PATGEN_FRAME_CNT_EN macro.
package hdmi_pkg;

  typedef enum logic [1:0] {
    PAT_RAMP    = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_FLAT    = 2'd3
  } pat_mode_t;

  typedef enum logic [1:0] {
    H_SYNC = 2'd0,
    H_BP   = 2'd1,
    H_ACT  = 2'd2,
    H_FP   = 2'd3
  } h_state_t;

  typedef enum logic [1:0] {
    V_SYNC = 2'd0,
    V_BP   = 2'd1,
    V_ACT  = 2'd2,
    V_FP   = 2'd3
  } v_state_t;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycc_t;

  // Width of the horizontal/vertical position counters.
  localparam int CNT_W = 16;

  // Default raster timing.
  localparam int DEF_N                   = 2;
  localparam int DEF_X_RES               = 2160;
  localparam int DEF_Y_RES               = 1200;
  localparam int DEF_H_SYNC_CYC          = 20;
  localparam int DEF_H_BACK_PORCH_CYC    = 46;
  localparam int DEF_H_FRONT_PORCH_CYC   = 40;
  localparam int DEF_V_SYNC_LINES        = 2;
  localparam int DEF_V_BACK_PORCH_LINES  = 234;
  localparam int DEF_V_FRONT_PORCH_LINES = 28;

  // Colour bars, index k = bar number: y = 127-32k, cb = 32k-128, cr = +/-100.
  localparam logic signed [7:0] BAR_Y [0:7] = '{
    8'sh7F, 8'sh5F, 8'sh3F, 8'sh1F, 8'shFF, 8'shDF, 8'shBF, 8'sh9F
  };
  localparam logic signed [7:0] BAR_CB [0:7] = '{
    8'sh80, 8'shA0, 8'shC0, 8'shE0, 8'sh00, 8'sh20, 8'sh40, 8'sh60
  };
  localparam logic signed [7:0] BAR_CR [0:7] = '{
    8'sh9C, 8'sh64, 8'sh9C, 8'sh64, 8'sh9C, 8'sh64, 8'sh9C, 8'sh64
  };

  // Luma amplitude of the checkerboard squares.
  localparam logic signed [7:0] CHECK_AMP = 8'sd100;

endpackage

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen: horizontal/vertical raster FSMs, registered sync/valid,
// active-region col/row and a frame_start strobe (first cycle of V_SYNC line 0).
// With HDMI_PATGEN_FRAME_CNT_EN defined it also keeps a 16-bit frame counter.
module hdmi_timing_gen
  import hdmi_pkg::*;
#(
  parameter int N                   = DEF_N,
  parameter int X_RES               = DEF_X_RES,
  parameter int Y_RES               = DEF_Y_RES,
  parameter int H_SYNC_CYC          = DEF_H_SYNC_CYC,
  parameter int H_BACK_PORCH_CYC    = DEF_H_BACK_PORCH_CYC,
  parameter int H_FRONT_PORCH_CYC   = DEF_H_FRONT_PORCH_CYC,
  parameter int V_SYNC_LINES        = DEF_V_SYNC_LINES,
  parameter int V_BACK_PORCH_LINES  = DEF_V_BACK_PORCH_LINES,
  parameter int V_FRONT_PORCH_LINES = DEF_V_FRONT_PORCH_LINES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             h_sync,
  output logic             v_sync,
  output logic             data_valid,
  output logic [CNT_W-1:0] col,
  output logic [7:0]       row,
  output logic             active,
  output logic             frame_start
`ifdef HDMI_PATGEN_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int COLS = X_RES / N;

  h_state_t         h_state;
  v_state_t         v_state;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_len;
  logic [CNT_W-1:0] v_len;
  logic             h_last;
  logic             v_last;

  // Length of the current horizontal state in clocks and vertical state in lines.
  always_comb begin
    h_len = CNT_W'(H_SYNC_CYC);
    v_len = CNT_W'(V_SYNC_LINES);
    case (h_state)
      H_SYNC:  h_len = CNT_W'(H_SYNC_CYC);
      H_BP:    h_len = CNT_W'(H_BACK_PORCH_CYC);
      H_ACT:   h_len = CNT_W'(COLS);
      H_FP:    h_len = CNT_W'(H_FRONT_PORCH_CYC);
      default: h_len = CNT_W'(H_SYNC_CYC);
    endcase
    case (v_state)
      V_SYNC:  v_len = CNT_W'(V_SYNC_LINES);
      V_BP:    v_len = CNT_W'(V_BACK_PORCH_LINES);
      V_ACT:   v_len = CNT_W'(Y_RES);
      V_FP:    v_len = CNT_W'(V_FRONT_PORCH_LINES);
      default: v_len = CNT_W'(V_SYNC_LINES);
    endcase
  end

  assign h_last      = (h_cnt == (h_len - 16'd1));
  assign v_last      = (v_cnt == (v_len - 16'd1));
  assign active      = (h_state == H_ACT) && (v_state == V_ACT);
  assign frame_start = (h_state == H_SYNC) && (h_cnt == 16'd0) &&
                       (v_state == V_SYNC) && (v_cnt == 16'd0);
  // Within the active window the state counters are the pixel position.
  assign col = (h_state == H_ACT) ? h_cnt : 16'd0;
  assign row = (v_state == V_ACT) ? v_cnt[7:0] : 8'd0;

  // Step the raster one clock and register sync/valid from the pre-step position.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_state    <= H_SYNC;
      v_state    <= V_SYNC;
      h_cnt      <= 16'd0;
      v_cnt      <= 16'd0;
      h_sync     <= 1'b0;
      v_sync     <= 1'b0;
      data_valid <= 1'b0;
`ifdef HDMI_PATGEN_FRAME_CNT_EN
      frame_cnt  <= 16'd0;
`endif
    end else if (en) begin
      h_sync     <= (h_state == H_SYNC);
      v_sync     <= (v_state == V_SYNC);
      data_valid <= active;
      if (h_last) begin
        h_cnt <= 16'd0;
        case (h_state)
          H_SYNC:  h_state <= H_BP;
          H_BP:    h_state <= H_ACT;
          H_ACT:   h_state <= H_FP;
          H_FP:    h_state <= H_SYNC;
          default: h_state <= H_SYNC;
        endcase
        // The vertical FSM moves only at the very end of a line.
        if (h_state == H_FP) begin
          if (v_last) begin
            v_cnt <= 16'd0;
            case (v_state)
              V_SYNC:  v_state <= V_BP;
              V_BP:    v_state <= V_ACT;
              V_ACT:   v_state <= V_FP;
              V_FP: begin
                v_state <= V_SYNC;
`ifdef HDMI_PATGEN_FRAME_CNT_EN
                frame_cnt <= frame_cnt + 16'd1;
`endif
              end
              default: v_state <= V_SYNC;
            endcase
          end else begin
            v_cnt <= v_cnt + 16'd1;
          end
        end
      end else begin
        h_cnt <= h_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: synthetic HDMI source producing raster timing and signed
// level-shifted YCbCr test patterns, N pixels per clock.
// Optional macro HDMI_PATGEN_FRAME_CNT_EN adds a frame_cnt output and makes the
// RAMP pattern scroll by one step per frame.
module hdmi_pattern_gen
  import hdmi_pkg::*;
#(
  parameter int N                   = DEF_N,
  parameter int X_RES               = DEF_X_RES,
  parameter int Y_RES               = DEF_Y_RES,
  parameter int H_SYNC_CYC          = DEF_H_SYNC_CYC,
  parameter int H_BACK_PORCH_CYC    = DEF_H_BACK_PORCH_CYC,
  parameter int H_FRONT_PORCH_CYC   = DEF_H_FRONT_PORCH_CYC,
  parameter int V_SYNC_LINES        = DEF_V_SYNC_LINES,
  parameter int V_BACK_PORCH_LINES  = DEF_V_BACK_PORCH_LINES,
  parameter int V_FRONT_PORCH_LINES = DEF_V_FRONT_PORCH_LINES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [1:0]     pat_mode,
  output logic           hdmi_v_sync,
  output logic           hdmi_h_sync,
  output logic           hdmi_data_valid,
  output logic [8*N-1:0] hdmi_data_y,
  output logic [8*N-1:0] hdmi_data_cb,
  output logic [8*N-1:0] hdmi_data_cr
`ifdef HDMI_PATGEN_FRAME_CNT_EN
  ,
  output logic [15:0]    frame_cnt
`endif
);

  // Bar width in pixels; always a whole number of columns.
  localparam int BAR_W = X_RES / 8;

  logic [CNT_W-1:0] col;
  logic [7:0]       row;
  logic             active;
  logic             frame_start;
  pat_mode_t        mode_q;
  logic [7:0]       off;
  logic [8*N-1:0]   y_nxt;
  logic [8*N-1:0]   cb_nxt;
  logic [8*N-1:0]   cr_nxt;
  ycc_t             px;

  hdmi_timing_gen #(
    .N                   (N),
    .X_RES               (X_RES),
    .Y_RES               (Y_RES),
    .H_SYNC_CYC          (H_SYNC_CYC),
    .H_BACK_PORCH_CYC    (H_BACK_PORCH_CYC),
    .H_FRONT_PORCH_CYC   (H_FRONT_PORCH_CYC),
    .V_SYNC_LINES        (V_SYNC_LINES),
    .V_BACK_PORCH_LINES  (V_BACK_PORCH_LINES),
    .V_FRONT_PORCH_LINES (V_FRONT_PORCH_LINES)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .h_sync      (hdmi_h_sync),
    .v_sync      (hdmi_v_sync),
    .data_valid  (hdmi_data_valid),
    .col         (col),
    .row         (row),
    .active      (active),
    .frame_start (frame_start)
`ifdef HDMI_PATGEN_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

`ifdef HDMI_PATGEN_FRAME_CNT_EN
  assign off = frame_cnt[7:0];
`else
  assign off = 8'd0;
`endif

  // Pixel value for pixel x on active row r; all arithmetic wraps at 8 bits.
  function automatic ycc_t pix(input pat_mode_t m, input logic [CNT_W-1:0] x,
                               input logic [7:0] r, input logic [7:0] o);
    ycc_t       p;
    logic [2:0] k;
    k = 3'(x / CNT_W'(BAR_W));
    p = ycc_t'(24'd0);
    case (m)
      PAT_RAMP: begin
        p.y  = x[7:0] + o;
        p.cb = r;
        p.cr = x[7:0] + r + o;
      end
      PAT_BARS: begin
        p.y  = BAR_Y[k];
        p.cb = BAR_CB[k];
        p.cr = BAR_CR[k];
      end
      PAT_CHECKER: p.y = (x[3] ^ r[3]) ? (8'd0 - CHECK_AMP) : CHECK_AMP;
      PAT_FLAT:    p   = ycc_t'(24'd0);
      default:     p   = ycc_t'(24'd0);
    endcase
    return p;
  endfunction

  // Hold the pattern for a whole frame: capture it on the frame's first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= pat_mode_t'(pat_mode);
    end else if (en && frame_start) begin
      mode_q <= pat_mode_t'(pat_mode);
    end
  end

  // Compute every lane for the current position; zero outside the active window.
  always_comb begin
    y_nxt  = {(8*N){1'b0}};
    cb_nxt = {(8*N){1'b0}};
    cr_nxt = {(8*N){1'b0}};
    px     = ycc_t'(24'd0);
    for (int i = 0; i < N; i++) begin
      px = pix(mode_q, col * CNT_W'(N) + CNT_W'(i), row, off);
      if (active) begin
        y_nxt[8*i +: 8]  = px.y;
        cb_nxt[8*i +: 8] = px.cb;
        cr_nxt[8*i +: 8] = px.cr;
      end else begin
        y_nxt[8*i +: 8]  = 8'd0;
        cb_nxt[8*i +: 8] = 8'd0;
        cr_nxt[8*i +: 8] = 8'd0;
      end
    end
  end

  // Register pixel data alongside the sync/valid registers in the timing block.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdmi_data_y  <= {(8*N){1'b0}};
      hdmi_data_cb <= {(8*N){1'b0}};
      hdmi_data_cr <= {(8*N){1'b0}};
    end else if (en) begin
      hdmi_data_y  <= y_nxt;
      hdmi_data_cb <= cb_nxt;
      hdmi_data_cr <= cr_nxt;
    end
  end

endmodule
